// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALU op codes, operand-select
// literals and arbiter state encodings.
package alu_share_arb_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLT  = 5'd2;
  localparam logic [4:0] ALU_SLTU = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_AND  = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_share_arb_if.sv
// One requester channel: valid/ready request carrying ALU fields, plus a
// valid/ready response. rsp_result is the arbiter's shared result bus.
interface alu_share_arb_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [4:0]      alucode;
  logic [XLEN-1:0] r1;
  logic [XLEN-1:0] r2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            using_r2;
  logic            using_pc;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;

  modport master (
    output req_valid, alucode, r1, r2, pc, imm, using_r2, using_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, alucode, r1, r2, pc, imm, using_r2, using_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu.sv
// Combinational integer ALU: selects operands (pc/r1, r2/imm) and computes the
// result for the given op code.
module alu
  import alu_share_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      alucode,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            using_r2,
  input  logic            using_pc,
  output logic [XLEN-1:0] alu_result
);
  localparam int SH_W = $clog2(XLEN);

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [SH_W-1:0] shamt;

  assign op1   = (using_pc == TRUE) ? pc : r1;
  assign op2   = (using_r2 == TRUE) ? r2 : imm;
  assign shamt = op2[SH_W-1:0];

  always_comb begin
    alu_result = '0;
    case (alucode)
      ALU_ADD:  alu_result = op1 + op2;
      ALU_SUB:  alu_result = op1 - op2;
      ALU_SLT:  alu_result[0] = ($signed(op1) < $signed(op2));
      ALU_SLTU: alu_result[0] = (op1 < op2);
      ALU_XOR:  alu_result = op1 ^ op2;
      ALU_OR:   alu_result = op1 | op2;
      ALU_AND:  alu_result = op1 & op2;
      ALU_SLL:  alu_result = op1 << shamt;
      ALU_SRL:  alu_result = op1 >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(op1) >>> shamt);
      default:  alu_result = '0;
    endcase
  end
endmodule

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin selector: a lone valid wins, a tie goes to the
// requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | last_grant);
    grant[1] = valid[1] & (~valid[0] | ~last_grant);
  end
endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one ALU between two requesters; one op in flight, registered
// result held until its owner takes it, back-to-back accept on retire.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  alu_share_arb_if.slave   ch0,
  alu_share_arb_if.slave   ch1,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);
  arb_state_e      state_reg, state_next;
  logic            owner_reg, owner_next;
  logic            last_grant_reg, last_grant_next;
  logic [1:0]      rsp_valid_reg, rsp_valid_next;
  logic [XLEN-1:0] result_reg, result_next;

  logic [1:0]      valid_vec;
  logic [1:0]      rsp_ready_vec;
  logic [1:0]      grant;
  logic [1:0]      req_ready_vec;
  logic            retire;
  logic            can_accept;
  logic            accept;

  logic [4:0]      alu_code_mux;
  logic [XLEN-1:0] r1_mux, r2_mux, pc_mux, imm_mux;
  logic            using_r2_mux, using_pc_mux;
  logic [XLEN-1:0] alu_result;

  assign valid_vec     = {ch1.req_valid, ch0.req_valid};
  assign rsp_ready_vec = {ch1.rsp_ready, ch0.rsp_ready};

  rr_arb2 u_rr_arb2 (
    .valid      (valid_vec),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  // A held response must retire before the ALU can be reused; only the
  // owner's rsp_ready matters.
  assign retire     = (state_reg == ARB_HOLD) && rsp_ready_vec[owner_reg];
  assign can_accept = rst_n && !flush && ((state_reg == ARB_IDLE) || retire);
  assign req_ready_vec = can_accept ? grant : 2'b00;
  assign accept        = |req_ready_vec;

  assign ch0.req_ready = req_ready_vec[0];
  assign ch1.req_ready = req_ready_vec[1];

  always_comb begin
    if (grant[1]) begin
      alu_code_mux = ch1.alucode;
      r1_mux       = ch1.r1;
      r2_mux       = ch1.r2;
      pc_mux       = ch1.pc;
      imm_mux      = ch1.imm;
      using_r2_mux = ch1.using_r2;
      using_pc_mux = ch1.using_pc;
    end else begin
      alu_code_mux = ch0.alucode;
      r1_mux       = ch0.r1;
      r2_mux       = ch0.r2;
      pc_mux       = ch0.pc;
      imm_mux      = ch0.imm;
      using_r2_mux = ch0.using_r2;
      using_pc_mux = ch0.using_pc;
    end
  end

  alu #(
    .XLEN (XLEN)
  ) u_alu (
    .alucode    (alu_code_mux),
    .r1         (r1_mux),
    .r2         (r2_mux),
    .pc         (pc_mux),
    .imm        (imm_mux),
    .using_r2   (using_r2_mux),
    .using_pc   (using_pc_mux),
    .alu_result (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      rsp_valid_reg  <= 2'b00;
      result_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      rsp_valid_reg  <= rsp_valid_next;
      result_reg     <= result_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    rsp_valid_next  = rsp_valid_reg;
    result_next     = result_reg;
    if (flush) begin
      state_next     = ARB_IDLE;
      rsp_valid_next = 2'b00;
    end else if (accept) begin
      state_next      = ARB_HOLD;
      owner_next      = req_ready_vec[1];
      last_grant_next = req_ready_vec[1];
      rsp_valid_next  = req_ready_vec;
      result_next     = alu_result;
    end else if (retire) begin
      state_next     = ARB_IDLE;
      rsp_valid_next = 2'b00;
    end
  end

  assign ch0.rsp_valid  = rsp_valid_reg[0];
  assign ch1.rsp_valid  = rsp_valid_reg[1];
  assign ch0.rsp_result = result_reg;
  assign ch1.rsp_result = result_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (req_ready_vec[gi] && (cnt_reg != {CNT_W{1'b1}}))
          cnt_next = cnt_reg + CNT_W'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_reg <= '0;
        else        cnt_reg <= cnt_next;
      end
    end
  endgenerate

  assign grant_cnt0 = g_cnt[0].cnt_reg;
  assign grant_cnt1 = g_cnt[1].cnt_reg;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: reset, single op, alternation, backpressure,
// flush, reset mid-operation and counter saturation (CNT_W = 2).
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int errors = 0;
  int checks = 0;

  alu_share_arb_if #(.XLEN(XLEN)) r0 ();
  alu_share_arb_if #(.XLEN(XLEN)) r1 ();

  alu_share_arb #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .ch0        (r0.slave),
    .ch1        (r1.slave),
    .grant_cnt0 (cnt0),
    .grant_cnt1 (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    r0.alucode = code; r0.r1 = a; r0.r2 = b; r0.pc = '0; r0.imm = '0;
    r0.using_r2 = TRUE; r0.using_pc = FALSE;
  endtask

  task automatic set_req1(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    r1.alucode = code; r1.r1 = a; r1.r2 = b; r1.pc = '0; r1.imm = '0;
    r1.using_r2 = TRUE; r1.using_pc = FALSE;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0;
    r0.req_valid = 1'b0; r1.req_valid = 1'b0;
    r0.rsp_ready = 1'b0; r1.rsp_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    r0.rsp_ready = 1'b0; r1.rsp_ready = 1'b0;
    set_req0(ALU_ADD, 32'd1, 32'd2);
    set_req1(ALU_ADD, 32'd3, 32'd4);
    r0.req_valid = 1'b1; r1.req_valid = 1'b0;
    #2;
    checks++; if (r0.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got=%b exp=0", r0.req_ready); end
    checks++; if (r0.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid got=%b exp=0", r0.rsp_valid); end
    checks++; if (r1.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid got=%b exp=0", r1.rsp_valid); end
    checks++; if (r0.rsp_result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", r0.rsp_result); end
    checks++; if (cnt0 !== 2'd0 || cnt1 !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
    r0.req_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_single_add();
    set_req0(ALU_ADD, 32'd34, 32'd55);
    r0.req_valid = 1'b1; r0.rsp_ready = 1'b1;
    #1;
    checks++; if (r0.req_ready !== 1'b1) begin errors++; $display("FAIL add_req0_ready got=%b exp=1", r0.req_ready); end
    checks++; if (r1.req_ready !== 1'b0) begin errors++; $display("FAIL add_req1_ready got=%b exp=0", r1.req_ready); end
    tick();
    r0.req_valid = 1'b0;
    #1;
    checks++; if (r0.rsp_valid !== 1'b1 || r1.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_valid got=%b%b exp=01", r1.rsp_valid, r0.rsp_valid); end
    checks++; if (r0.rsp_result !== 32'd89) begin errors++; $display("FAIL add_result got=%0d exp=89", r0.rsp_result); end
    checks++; if (cnt0 !== 2'd1) begin errors++; $display("FAIL add_cnt0 got=%0d exp=1", cnt0); end
    $display("txn req0 ADD 34+55 -> %0d", r0.rsp_result);
    tick();
    checks++; if (r0.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_retire got=%b exp=0", r0.rsp_valid); end
  endtask

  task automatic test_fairness();
    logic        exp_g;
    logic        prev_g;
    logic [31:0] exp_res;
    do_reset();
    set_req0(ALU_SUB, 32'd55, 32'd56);
    set_req1(ALU_SLTU, 32'hBADCAB1E, 32'hFEEDFACE);
    r0.req_valid = 1'b1; r1.req_valid = 1'b1;
    r0.rsp_ready = 1'b1; r1.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_g = i[0];
      #1;
      checks++; if (r0.req_ready !== ~exp_g || r1.req_ready !== exp_g) begin errors++; $display("FAIL fair_grant[%0d] got=%b%b exp_grant=%0d", i, r1.req_ready, r0.req_ready, exp_g); end
      if (i > 0) begin
        prev_g  = ~exp_g;
        exp_res = prev_g ? 32'h1 : 32'hFFFFFFFF;
        checks++; if (r0.rsp_valid !== ~prev_g || r1.rsp_valid !== prev_g) begin errors++; $display("FAIL fair_rsp_valid[%0d] got=%b%b exp_owner=%0d", i, r1.rsp_valid, r0.rsp_valid, prev_g); end
        checks++; if (r0.rsp_result !== exp_res) begin errors++; $display("FAIL fair_result[%0d] got=%h exp=%h", i, r0.rsp_result, exp_res); end
      end
      $display("txn fair cycle %0d grant req%0d", i, exp_g);
      tick();
    end
    r0.req_valid = 1'b0; r1.req_valid = 1'b0;
    #1;
    checks++; if (r1.rsp_valid !== 1'b1 || r1.rsp_result !== 32'h1) begin errors++; $display("FAIL fair_last got=%b/%h exp=1/00000001", r1.rsp_valid, r1.rsp_result); end
    tick();
  endtask

  task automatic test_backpressure();
    set_req1(ALU_SRA, 32'hDEADDEAD, 32'd16);
    r1.req_valid = 1'b1; r1.rsp_ready = 1'b0; r0.rsp_ready = 1'b1;
    #1;
    checks++; if (r1.req_ready !== 1'b1) begin errors++; $display("FAIL bp_req1_ready got=%b exp=1", r1.req_ready); end
    tick();
    r1.req_valid = 1'b0;
    set_req0(ALU_ADD, 32'd34, 32'd55);
    r0.req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (r1.rsp_valid !== 1'b1 || r1.rsp_result !== 32'hFFFFDEAD) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/ffffdead", k, r1.rsp_valid, r1.rsp_result); end
      checks++; if (r0.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req0_blocked[%0d] got=%b exp=0", k, r0.req_ready); end
      $display("txn bp stall %0d result %h", k, r1.rsp_result);
      tick();
    end
    r1.rsp_ready = 1'b1;
    #1;
    checks++; if (r0.req_ready !== 1'b1) begin errors++; $display("FAIL bp_req0_on_retire got=%b exp=1", r0.req_ready); end
    tick();
    r0.req_valid = 1'b0;
    #1;
    checks++; if (r0.rsp_valid !== 1'b1 || r1.rsp_valid !== 1'b0 || r0.rsp_result !== 32'd89) begin errors++; $display("FAIL bp_next got=%b%b/%0d exp=01/89", r1.rsp_valid, r0.rsp_valid, r0.rsp_result); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_req0(ALU_ADD, 32'd34, 32'd55);
    r0.req_valid = 1'b1; r0.rsp_ready = 1'b0;
    tick();
    r0.req_valid = 1'b0;
    set_req1(ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0);
    r1.req_valid = 1'b1; r0.rsp_ready = 1'b1; r1.rsp_ready = 1'b0;
    flush = 1'b1;
    #1;
    checks++; if (r0.rsp_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_hold got=%b exp=1", r0.rsp_valid); end
    checks++; if (r1.req_ready !== 1'b0) begin errors++; $display("FAIL flush_req1_ready got=%b exp=0", r1.req_ready); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (r0.rsp_valid !== 1'b0 || r1.rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_valid got=%b%b exp=00", r1.rsp_valid, r0.rsp_valid); end
    checks++; if (cnt0 !== 2'd1 || cnt1 !== 2'd0) begin errors++; $display("FAIL flush_cnt got=%0d/%0d exp=1/0", cnt0, cnt1); end
    checks++; if (r1.req_ready !== 1'b1) begin errors++; $display("FAIL flush_req1_after got=%b exp=1", r1.req_ready); end
    tick();
    r1.req_valid = 1'b0;
    #1;
    checks++; if (r1.rsp_valid !== 1'b1 || r1.rsp_result !== 32'hFF00FF00 || cnt1 !== 2'd1) begin errors++; $display("FAIL flush_req1_rsp got=%b/%h/%0d exp=1/ff00ff00/1", r1.rsp_valid, r1.rsp_result, cnt1); end
    $display("txn req1 XOR after flush -> %h", r1.rsp_result);
    r1.rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_midop();
    set_req1(ALU_SLL, 32'hFEEDFACE, 32'd1036);
    r1.req_valid = 1'b1; r1.rsp_ready = 1'b0;
    #1;
    tick();
    r1.req_valid = 1'b0;
    #1;
    checks++; if (r1.rsp_valid !== 1'b1 || r1.rsp_result !== 32'hDFACE000) begin errors++; $display("FAIL midop_hold got=%b/%h exp=1/dface000", r1.rsp_valid, r1.rsp_result); end
    rst_n = 1'b0;
    #1;
    checks++; if (r1.rsp_valid !== 1'b0 || r1.rsp_result !== 32'h0) begin errors++; $display("FAIL midop_reset got=%b/%h exp=0/00000000", r1.rsp_valid, r1.rsp_result); end
    tick();
    set_req0(ALU_ADD, 32'd34, 32'd55);
    r0.req_valid = 1'b1; r1.req_valid = 1'b1; r0.rsp_ready = 1'b1;
    #1;
    checks++; if (r0.req_ready !== 1'b0 || r1.req_ready !== 1'b0) begin errors++; $display("FAIL midop_ready_in_reset got=%b%b exp=00", r1.req_ready, r0.req_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (r0.req_ready !== 1'b1 || r1.req_ready !== 1'b0) begin errors++; $display("FAIL midop_first_tie got=%b%b exp=01", r1.req_ready, r0.req_ready); end
    tick();
    r0.req_valid = 1'b0; r1.req_valid = 1'b0;
    #1;
    checks++; if (r0.rsp_valid !== 1'b1 || r1.rsp_valid !== 1'b0 || r0.rsp_result !== 32'd89) begin errors++; $display("FAIL midop_after got=%b%b/%0d exp=01/89", r1.rsp_valid, r0.rsp_valid, r0.rsp_result); end
    $display("txn reset mid-op, first tie to req0 -> %0d", r0.rsp_result);
    tick();
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    set_req0(ALU_ADD, 32'd34, 32'd55);
    r0.req_valid = 1'b1; r0.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_cnt = (k < 3) ? CNT_W'(k + 1) : 2'd3;
      tick();
      checks++; if (cnt0 !== exp_cnt) begin errors++; $display("FAIL sat_cnt0[%0d] got=%0d exp=%0d", k, cnt0, exp_cnt); end
      $display("txn sat op %0d grant_cnt0=%0d", k, cnt0);
    end
    r0.req_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_fairness();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Two-requester round-robin arbiter that time-shares one instance of the existing `alu` between requesters 0 and 1.
  - Requester 0 is the integer execute path.
  - Requester 1 is the branch/AGU helper path.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Only one operation is in flight at a time. The result is registered and held until its owner accepts it.

Parameters:
- XLEN, 32, operand/result width; must match `alu`.
- CNT_W, 16, width of the per-requester grant counters (saturating).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of any held response
- reqN_valid  in  1  request N valid (N=0,1; all reqN_*/rspN_* ports exist once per requester)
- reqN_ready  out  1  request N accepted this cycle when high with reqN_valid
- reqN_alucode  in  5  ALU op code (ADD, SUB, SLT, SLTu, XOR, OR, AND, SLL, SRL, SRA)
- reqN_r1, reqN_r2, reqN_pc, reqN_imm  in  XLEN  ALU operands
- reqN_using_r2, reqN_using_pc  in  1  ALU operand selects (TRUE/FALSE)
- rspN_valid  out  1  result for requester N held
- rspN_ready  in  1  requester N consumes result
- rsp_result  out  XLEN  held result; shared bus, qualified by rspN_valid
- grant_cnt0, grant_cnt1  out  CNT_W  accepted-request counters

Behaviour:
- Reset (rst_n low, async) clears:
  - all rspN_valid = 0
  - rsp_result = 0
  - grant_cnt0/1 = 0
  - state = IDLE
  - last_grant = 1, so requester 0 wins the first tie.
- reqN_ready is combinational:
  - high only for the selected requester;
  - low for both while reset is asserted and while flush = 1.
- States: IDLE, HOLD.
- IDLE:
  - Selection:
    - only one valid → grant it;
    - both valid → grant the requester != last_grant.
  - The ALU input mux drives the granted request's fields combinationally into `alu`.
  - On the accept edge:
    - rsp_result <= alu_result;
    - rspG_valid <= 1;
    - last_grant <= G;
    - grant_cntG increments, saturating at all-ones;
    - state -> HOLD.
  - Latency: request accepted in cycle N → response valid in cycle N+1.
- HOLD (owner O):
  - rspO_valid = 1 and rsp_result stays stable until rspO_ready.
  - If rspO_ready = 0: both reqN_ready = 0.
  - If rspO_ready = 1, the response retires this cycle, and the arbiter may accept a new request in the same cycle (back-to-back, one op per cycle sustained).
    - Arbitration is as in IDLE, using the updated priority.
    - Accept → stay in HOLD with the new owner and result. No accept → IDLE.
- Invariants:
  - The non-owner's rsp_ready is ignored.
  - Never both rspN_valid high at once.
- flush = 1, synchronous:
  - next state IDLE, both rspN_valid <= 0;
  - no accept that cycle;
  - counters unchanged;
  - flush overrides a simultaneous rspO_ready or request.
- Fairness: with both requesters valid continuously and responses accepted immediately, grants strictly alternate 0,1,0,1…
- Reset asserted mid-operation drops the held response immediately. No stale rspN_valid after release.
- The arithmetic is entirely the ALU's. This block never modifies operands or the result.
- A requester must hold its request fields stable while reqN_valid = 1 and not yet accepted.

Decomposition:
- ALU op codes and TRUE/FALSE come from the shared `99_define.vh`. Add ARB_IDLE/ARB_HOLD state encodings there.
- Sub-modules:
  - instantiate the existing `alu` unchanged;
  - factor a small `rr_arb2` sub-module (two valids + last_grant → one-hot grant). It is natural and reusable.

Test Plan:
- After reset, only req0 valid, ADD r1 = 34, r2 = 55, rsp0_ready = 1 → req0_ready = 1 in cycle 0; rsp0_valid = 1 with rsp_result = 89 in cycle 1; grant_cnt0 = 1.
- Both valid continuously: req0 SUB 55, 56; req1 SLTu 0xBADCAB1E, 0xFEEDFACE; both rsp_ready = 1 → grants alternate 0,1,0,1; results 0xFFFFFFFF and 0x1 on the matching rspN_valid.
- Backpressure: req1 SRA 0xDEADDEAD, 16 with rsp1_ready = 0 for 3 cycles and req0 valid → rsp_result holds 0xFFFFDEAD; req0_ready = 0 throughout; req0 is granted in the cycle rsp1_ready rises.
- Flush: flush = 1 during HOLD with rsp0_ready = 1 and req1 valid → both rspN_valid = 0 next cycle; req1 not accepted that cycle; req1 accepted the cycle after flush drops.
- Reset mid-op: assert rst_n = 0 while rsp1_valid = 1 (SLL 0xFEEDFACE, 1036 → 0xDFACE000 held) → rsp1_valid = 0 and rsp_result = 0 immediately; after release, the first tie goes to requester 0.
- Counter saturation with CNT_W = 2: 5 accepted req0 ops → grant_cnt0 reads 1, 2, 3, 3, 3.
